// File: rtl/asteroid_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// asteroid_scheduler - round-robin spawner, step pacer and retire control for asteroid slots
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module asteroid_scheduler #(
  parameter int          NUM_SLOTS    = 4,
  parameter int          SPAWN_PERIOD = 25000000,
  parameter int          STEP_PERIOD  = 2500000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [8*NUM_SLOTS-1:0] slot_x,
  input  logic [7*NUM_SLOTS-1:0] slot_y,
  input  logic [NUM_SLOTS-1:0]   slot_hit,
  output logic [NUM_SLOTS-1:0]   slot_reset,
  output logic [NUM_SLOTS-1:0]   slot_start,
  output logic [4*NUM_SLOTS-1:0] slot_direct,
  output logic [NUM_SLOTS-1:0]   active,
  output logic [3:0]             active_count,
  output logic                   spawn_event,
  output logic                   spawn_miss,
  output logic [2:0]             spawned_slot
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SEARCH = 2'd1,
    S_LOAD   = 2'd2,
    S_LAUNCH = 2'd3
  } state_t;

  localparam logic [31:0] SPAWN_RELOAD = 32'(SPAWN_PERIOD - 1);
  localparam logic [31:0] STEP_RELOAD  = 32'(STEP_PERIOD - 1);
  localparam logic [2:0]  LAST_SLOT    = 3'(NUM_SLOTS - 1);

  state_t                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [31:0]            spawn_cnt_q, spawn_cnt_d;
  logic [31:0]            step_cnt_q, step_cnt_d;
  logic [2:0]             spawned_slot_q, spawned_slot_d;
  logic [NUM_SLOTS-1:0]   active_q, active_d;
  logic [NUM_SLOTS-1:0]   slot_reset_q, slot_reset_d;
  logic [NUM_SLOTS-1:0]   slot_start_q, slot_start_d;
  logic [4*NUM_SLOTS-1:0] slot_direct_q, slot_direct_d;
  logic                   spawn_event_q, spawn_event_d;
  logic                   spawn_miss_q, spawn_miss_d;

  logic                   step_tick;
  logic [NUM_SLOTS-1:0]   retire;
  logic [7:0]             active_ext;
  logic                   found;
  logic [2:0]             cand;
  logic [2:0]             free_slot;

  function automatic logic [3:0] dir_lut(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4'b0010;
      3'd1:    return 4'b1010;
      3'd2:    return 4'b1000;
      3'd3:    return 4'b1001;
      3'd4:    return 4'b0001;
      3'd5:    return 4'b0101;
      3'd6:    return 4'b0100;
      default: return 4'b0110;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    spawn_cnt_d    = spawn_cnt_q;
    step_cnt_d     = step_cnt_q;
    spawned_slot_d = spawned_slot_q;
    active_d       = active_q;
    slot_direct_d  = slot_direct_q;
    slot_reset_d   = '0;
    slot_start_d   = '0;
    spawn_event_d  = 1'b0;
    spawn_miss_d   = 1'b0;
    step_tick      = 1'b0;
    retire         = '0;
    active_ext     = 8'(active_q);
    found          = 1'b0;
    cand           = '0;
    free_slot      = '0;

    // Both counters free-run so spawn attempts stay exactly SPAWN_PERIOD apart.
    if (enable) begin
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      spawn_cnt_d = (spawn_cnt_q == '0) ? SPAWN_RELOAD : spawn_cnt_q - 32'd1;
      if (step_cnt_q == '0) begin
        step_cnt_d = STEP_RELOAD;
        step_tick  = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q - 32'd1;
      end
    end

    for (int k = 0; k < NUM_SLOTS; k++) begin
      cand = 3'((int'(spawned_slot_q) + 1 + k) % NUM_SLOTS);
      if (!found && !active_ext[cand]) begin
        found     = 1'b1;
        free_slot = cand;
      end
    end

    // Pulses are registered, so each one is set up one state ahead of where it is seen.
    case (state_q)
      S_WAIT: begin
        if (enable && spawn_cnt_q == '0) state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (found) begin
          spawned_slot_d = free_slot;
          state_d        = S_LOAD;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (free_slot == 3'(i)) begin
              slot_direct_d[4*i +: 4] = dir_lut(lfsr_q[2:0]);
              slot_reset_d[i]         = 1'b1;
            end
          end
        end else begin
          spawn_miss_d = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_LOAD: begin
        state_d       = S_LAUNCH;
        spawn_event_d = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (spawned_slot_q == 3'(i)) begin
            active_d[i]     = 1'b1;
            slot_start_d[i] = 1'b1;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase

    // Retire wins over a coincident step pulse.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      retire[i] = active_q[i] & (slot_hit[i] | (slot_x[8*i +: 8] > 8'd159) |
                                 (slot_y[7*i +: 7] > 7'd119));
      if (step_tick && active_q[i]) slot_start_d[i] = 1'b1;
      if (retire[i]) begin
        active_d[i]             = 1'b0;
        slot_reset_d[i]         = 1'b1;
        slot_start_d[i]         = 1'b0;
        slot_direct_d[4*i +: 4] = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_WAIT;
      lfsr_q         <= LFSR_SEED;
      spawn_cnt_q    <= SPAWN_RELOAD;
      step_cnt_q     <= STEP_RELOAD;
      spawned_slot_q <= LAST_SLOT;
      active_q       <= '0;
      slot_reset_q   <= '0;
      slot_start_q   <= '0;
      slot_direct_q  <= '0;
      spawn_event_q  <= 1'b0;
      spawn_miss_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      spawn_cnt_q    <= spawn_cnt_d;
      step_cnt_q     <= step_cnt_d;
      spawned_slot_q <= spawned_slot_d;
      active_q       <= active_d;
      slot_reset_q   <= slot_reset_d;
      slot_start_q   <= slot_start_d;
      slot_direct_q  <= slot_direct_d;
      spawn_event_q  <= spawn_event_d;
      spawn_miss_q   <= spawn_miss_d;
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) active_count = active_count + 4'(active_q[i]);
  end

  assign slot_reset   = slot_reset_q;
  assign slot_start   = slot_start_q;
  assign slot_direct  = slot_direct_q;
  assign active       = active_q;
  assign spawn_event  = spawn_event_q;
  assign spawn_miss   = spawn_miss_q;
  assign spawned_slot = spawned_slot_q;

endmodule
`default_nettype wire

// File: tb/tb_asteroid_scheduler.sv
`default_nettype none
// tb_asteroid_scheduler: cycle-indexed vector table plus hand sequences for pacing and reset abort.
module tb_asteroid_scheduler;
  localparam int          N    = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] slot_x;
  logic [27:0] slot_y;
  logic [3:0]  slot_hit;
  logic [3:0]  slot_reset;
  logic [3:0]  slot_start;
  logic [15:0] slot_direct;
  logic [3:0]  active;
  logic [3:0]  active_count;
  logic        spawn_event;
  logic        spawn_miss;
  logic [2:0]  spawned_slot;

  always #5 clk = ~clk;

  asteroid_scheduler #(
    .NUM_SLOTS(N), .SPAWN_PERIOD(8), .STEP_PERIOD(4), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .slot_x(slot_x), .slot_y(slot_y), .slot_hit(slot_hit),
    .slot_reset(slot_reset), .slot_start(slot_start), .slot_direct(slot_direct),
    .active(active), .active_count(active_count),
    .spawn_event(spawn_event), .spawn_miss(spawn_miss), .spawned_slot(spawned_slot)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  hit;
    logic [31:0] x;
    logic [27:0] y;
    logic [3:0]  e_reset;
    logic [3:0]  e_start;
    logic [3:0]  e_active;
    logic        e_event;
    logic        e_miss;
    logic [2:0]  e_spawned;
    logic [15:0] e_dir;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic [3:0]  da, db, dc, dd, de, df;
  logic [15:0] z16;

  function automatic logic [3:0] lut(input logic [2:0] s);
    case (s)
      3'd0:    return 4'b0010;
      3'd1:    return 4'b1010;
      3'd2:    return 4'b1000;
      3'd3:    return 4'b1001;
      3'd4:    return 4'b0001;
      3'd5:    return 4'b0101;
      3'd6:    return 4'b0100;
      default: return 4'b0110;
    endcase
  endfunction

  // Direction expected from an LFSR that has advanced n times from the seed.
  function automatic logic [3:0] dirk(input int n);
    logic [15:0] l;
    l = SEED;
    for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return lut(l[2:0]);
  endfunction

  function automatic logic [15:0] pk(input logic [3:0] d3, input logic [3:0] d2,
                                     input logic [3:0] d1, input logic [3:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic add(input int c, input logic [3:0] h, input logic [31:0] x, input logic [27:0] y,
                     input logic [3:0] r, input logic [3:0] s, input logic [3:0] a,
                     input logic ev, input logic ms, input logic [2:0] sp, input logic [15:0] d);
    vec_t v;
    v.cyc = c; v.hit = h; v.x = x; v.y = y;
    v.e_reset = r; v.e_start = s; v.e_active = a;
    v.e_event = ev; v.e_miss = ms; v.e_spawned = sp; v.e_dir = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v);
    check("slot_reset",   32'(slot_reset),   32'(v.e_reset));
    check("slot_start",   32'(slot_start),   32'(v.e_start));
    check("active",       32'(active),       32'(v.e_active));
    check("active_count", 32'(active_count), 32'($countones(v.e_active)));
    check("spawn_event",  32'(spawn_event),  32'(v.e_event));
    check("spawn_miss",   32'(spawn_miss),   32'(v.e_miss));
    check("spawned_slot", 32'(spawned_slot), 32'(v.e_spawned));
    check("slot_direct",  32'(slot_direct),  32'(v.e_dir));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    slot_hit = '0;
  endtask

  // Leaves the bench on the negedge right after the last reset edge (cycle 0).
  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    cyc    = 0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; slot_x = '0; slot_y = '0; slot_hit = '0;
    z16 = 16'h0;
    da = dirk(8); db = dirk(16); dc = dirk(24); dd = dirk(32); de = dirk(48); df = dirk(56);

    // cyc, hit, x, y | reset, start, active, event, miss, spawned, direct
    add( 0, 4'h0, 32'h0, 28'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd3, z16);
    add( 7, 4'h0, 32'h0, 28'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd3, z16);
    add( 8, 4'h0, 32'h0, 28'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd3, z16);
    add( 9, 4'h0, 32'h0, 28'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, pk(4'h0, 4'h0, 4'h0, da));
    add(10, 4'h0, 32'h0, 28'h0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 3'd0, pk(4'h0, 4'h0, 4'h0, da));
    add(11, 4'h0, 32'h0, 28'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 3'd0, pk(4'h0, 4'h0, 4'h0, da));
    add(12, 4'h0, 32'h0, 28'h0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0, 3'd0, pk(4'h0, 4'h0, 4'h0, da));
    add(17, 4'h0, 32'h0, 28'h0, 4'h2, 4'h0, 4'h1, 1'b0, 1'b0, 3'd1, pk(4'h0, 4'h0, db, da));
    add(18, 4'h0, 32'h0, 28'h0, 4'h0, 4'h2, 4'h3, 1'b1, 1'b0, 3'd1, pk(4'h0, 4'h0, db, da));
    add(20, 4'h0, 32'h0, 28'h0, 4'h0, 4'h3, 4'h3, 1'b0, 1'b0, 3'd1, pk(4'h0, 4'h0, db, da));
    add(25, 4'h0, 32'h0, 28'h0, 4'h4, 4'h0, 4'h3, 1'b0, 1'b0, 3'd2, pk(4'h0, dc, db, da));
    add(26, 4'h0, 32'h0, 28'h0, 4'h0, 4'h4, 4'h7, 1'b1, 1'b0, 3'd2, pk(4'h0, dc, db, da));
    add(28, 4'h0, 32'h0, 28'h0, 4'h0, 4'h7, 4'h7, 1'b0, 1'b0, 3'd2, pk(4'h0, dc, db, da));
    add(33, 4'h0, 32'h0, 28'h0, 4'h8, 4'h0, 4'h7, 1'b0, 1'b0, 3'd3, pk(dd, dc, db, da));
    add(34, 4'h0, 32'h0, 28'h0, 4'h0, 4'h8, 4'hF, 1'b1, 1'b0, 3'd3, pk(dd, dc, db, da));
    add(36, 4'h0, 32'h0, 28'h0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 3'd3, pk(dd, dc, db, da));
    add(40, 4'h0, 32'h0, 28'h0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 3'd3, pk(dd, dc, db, da));
    add(41, 4'h0, 32'h0, 28'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b1, 3'd3, pk(dd, dc, db, da));
    add(42, 4'h0, 32'h0, 28'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 3'd3, pk(dd, dc, db, da));
    add(44, 4'h4, 32'h0, 28'h0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 3'd3, pk(dd, dc, db, da));
    add(45, 4'h0, 32'h0, 28'h0, 4'h4, 4'h0, 4'hB, 1'b0, 1'b0, 3'd3, pk(dd, 4'h0, db, da));
    add(48, 4'h0, 32'h0, 28'h0, 4'h0, 4'hB, 4'hB, 1'b0, 1'b0, 3'd3, pk(dd, 4'h0, db, da));
    add(49, 4'h0, 32'h0, 28'h0, 4'h4, 4'h0, 4'hB, 1'b0, 1'b0, 3'd2, pk(dd, de, db, da));
    add(50, 4'h0, 32'h0, 28'h0, 4'h0, 4'h4, 4'hF, 1'b1, 1'b0, 3'd2, pk(dd, de, db, da));
    add(51, 4'h2, 32'h0, 28'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 3'd2, pk(dd, de, db, da));
    add(52, 4'h0, 32'h0, 28'h0, 4'h2, 4'hD, 4'hD, 1'b0, 1'b0, 3'd2, pk(dd, de, 4'h0, da));
    add(53, 4'h0, 32'hFD, 28'h0, 4'h0, 4'h0, 4'hD, 1'b0, 1'b0, 3'd2, pk(dd, de, 4'h0, da));
    add(54, 4'h0, 32'h0, 28'd122 << 14, 4'h1, 4'h0, 4'hC, 1'b0, 1'b0, 3'd2, pk(dd, de, 4'h0, 4'h0));
    add(55, 4'h0, 32'h0, 28'h0, 4'h4, 4'h0, 4'h8, 1'b0, 1'b0, 3'd2, pk(dd, 4'h0, 4'h0, 4'h0));
    add(56, 4'h8, 32'h0, 28'h0, 4'h0, 4'h8, 4'h8, 1'b0, 1'b0, 3'd2, pk(dd, 4'h0, 4'h0, 4'h0));
    add(57, 4'h0, 32'h0, 28'h0, 4'h9, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, pk(4'h0, 4'h0, 4'h0, df));
    add(58, 4'h0, 32'h9F, 28'd119, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 3'd0, pk(4'h0, 4'h0, 4'h0, df));
    add(59, 4'h0, 32'h9F, 28'd119, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 3'd0, pk(4'h0, 4'h0, 4'h0, df));
    add(60, 4'h0, 32'h0, 28'h0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0, 3'd0, pk(4'h0, 4'h0, 4'h0, df));
    add(61, 4'h0, 32'h0, 28'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 3'd0, pk(4'h0, 4'h0, 4'h0, df));

    do_reset();
    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) tick();
      check_vec(vecs[i]);
      slot_hit = vecs[i].hit;
      slot_x   = vecs[i].x;
      slot_y   = vecs[i].y;
    end

    // Pacing with three active slots and a 10-cycle enable drop.
    slot_x = '0; slot_y = '0; slot_hit = '0;
    do_reset();
    while (cyc < 24) tick();
    check("pace_s24", 32'(slot_start), 32'h3);
    while (cyc < 28) tick();
    check("pace_s28", 32'(slot_start), 32'h7);
    tick();
    check("pace_s29", 32'(slot_start), 32'h0);
    enable = 1'b0;
    for (int k = 30; k <= 39; k++) begin
      tick();
      check("hold_start", 32'(slot_start), 32'h0);
      check("hold_reset", 32'(slot_reset), 32'h0);
    end
    enable = 1'b1;
    tick();
    check("resume_s40", 32'(slot_start), 32'h0);
    tick();
    check("resume_s41", 32'(slot_start), 32'h0);
    tick();
    check("resume_start", 32'(slot_start), 32'h7);
    check("resume_count", 32'(active_count), 32'd3);
    tick();
    check("resume_reset", 32'(slot_reset), 32'h8);
    check("lfsr_hold_dir", 32'(slot_direct[15:12]), 32'(dirk(32)));
    tick();
    check("resume_launch", 32'(slot_start), 32'h8);
    check("resume_active", 32'(active), 32'hF);
    tick();
    tick();
    check("resume_step", 32'(slot_start), 32'hF);

    // Reset asserted during SEARCH aborts the spawn with no pulses.
    do_reset();
    while (cyc < 8) tick();
    reset = 1'b1;
    tick();
    check("abort_reset", 32'(slot_reset), 32'h0);
    check("abort_start", 32'(slot_start), 32'h0);
    check("abort_active", 32'(active), 32'h0);
    check("abort_spawned", 32'(spawned_slot), 32'd3);
    reset = 1'b0;
    cyc   = 0;
    while (cyc < 9) tick();
    check("rerun_reset", 32'(slot_reset), 32'h1);
    tick();
    check("rerun_active", 32'(active), 32'h1);
    check("rerun_event", 32'(spawn_event), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
